// File: rtl/bus_port_pkg.sv
// Shared definitions for the bus port buffer and its neighbours.
//   cnt_w(depth) : width of an occupancy counter that can hold 0..depth.
//   ID_MSB_OFS   : width of the destination-ID field at the top of a packet.
package bus_port_pkg;

  localparam int unsigned ID_MSB_OFS = 8;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular queue with first-word fall-through head.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   wr_i, wdata_i  enqueue request and data
//   rd_i           dequeue request (ignored while empty)
//   ovf_clr_i      clears the sticky drop flag
//   rdata_o        head entry, forced to 0 while empty
//   full_o/empty_o occupancy flags derived from the registered count
//   count_o        occupancy
//   ovf_o          sticky flag, set when a write is dropped
module sync_fifo
  import bus_port_pkg::*;
#(
  parameter int unsigned pckg_sz = 16,
  parameter int unsigned depth   = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_i,
  input  logic [pckg_sz-1:0]        wdata_i,
  input  logic                      rd_i,
  input  logic                      ovf_clr_i,
  output logic [pckg_sz-1:0]        rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [cnt_w(depth)-1:0]   count_o,
  output logic                      ovf_o
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam int unsigned CntW = cnt_w(depth);

  logic [pckg_sz-1:0] mem_q [depth];
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               wr_ok, rd_ok, drop;

  assign full_o  = (count_q == CntW'(depth));
  assign empty_o = (count_q == '0);

  // A read frees a slot in the same cycle, so a write while full still fits if a read
  // is happening. A read while empty is ignored, even alongside a write.
  assign rd_ok = rd_i & ~empty_o;
  assign wr_ok = wr_i & (~full_o | rd_i);
  assign drop  = wr_i & full_o & ~rd_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (wr_ok && !rd_ok)      count_d = count_q + CntW'(1);
    else if (rd_ok && !wr_ok) count_d = count_q - CntW'(1);
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)           ovf_d = 1'b1;
    else if (ovf_clr_i) ovf_d = 1'b0;
    else                ovf_d = ovf_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage has no reset; the zero-when-empty head hides stale contents.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/bus_port_fifo.sv
// Per-driver port buffer between a host agent and the bus arbiter.
// TX queue: host writes (wr_en/wr_data), arbiter sees pndng/D_pop and consumes with pop.
// RX queue: arbiter delivers with push/D_push, host reads rd_data and consumes with rd_en.
// Status: tx_full, tx_count, rx_empty, rx_count, sticky tx_ovf/rx_ovf cleared by ovf_clr.
// Port names follow the bus generator's existing naming.
module bus_port_fifo
  import bus_port_pkg::*;
#(
  parameter int unsigned pckg_sz = 16,
  parameter int unsigned depth   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [pckg_sz-1:0]      wr_data,
  output logic                    tx_full,
  output logic [cnt_w(depth)-1:0] tx_count,
  output logic                    pndng,
  output logic [pckg_sz-1:0]      D_pop,
  input  logic                    pop,
  input  logic                    push,
  input  logic [pckg_sz-1:0]      D_push,
  input  logic                    rd_en,
  output logic [pckg_sz-1:0]      rd_data,
  output logic                    rx_empty,
  output logic [cnt_w(depth)-1:0] rx_count,
  output logic                    tx_ovf,
  output logic                    rx_ovf,
  input  logic                    ovf_clr
);

  logic tx_empty;
  logic unused_rx_full;

  sync_fifo #(
    .pckg_sz (pckg_sz),
    .depth   (depth)
  ) u_tx_fifo (
    .clk_i     (clk),
    .rst_i     (reset),
    .wr_i      (wr_en),
    .wdata_i   (wr_data),
    .rd_i      (pop),
    .ovf_clr_i (ovf_clr),
    .rdata_o   (D_pop),
    .full_o    (tx_full),
    .empty_o   (tx_empty),
    .count_o   (tx_count),
    .ovf_o     (tx_ovf)
  );

  sync_fifo #(
    .pckg_sz (pckg_sz),
    .depth   (depth)
  ) u_rx_fifo (
    .clk_i     (clk),
    .rst_i     (reset),
    .wr_i      (push),
    .wdata_i   (D_push),
    .rd_i      (rd_en),
    .ovf_clr_i (ovf_clr),
    .rdata_o   (rd_data),
    .full_o    (unused_rx_full),
    .empty_o   (rx_empty),
    .count_o   (rx_count),
    .ovf_o     (rx_ovf)
  );

  // Registered-count based, so pop never feeds back into pndng combinationally.
  assign pndng = ~tx_empty;

endmodule

// File: tb/tb_bus_port_fifo.sv
module tb_bus_port_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        tx_full;
  logic [3:0]  tx_count;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rx_empty;
  logic [3:0]  rx_count;
  logic        tx_ovf;
  logic        rx_ovf;
  logic        ovf_clr;

  int checks   = 0;
  int failures = 0;

  bus_port_fifo #(
    .pckg_sz (16),
    .depth   (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .tx_full  (tx_full),
    .tx_count (tx_count),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rx_empty (rx_empty),
    .rx_count (rx_count),
    .tx_ovf   (tx_ovf),
    .rx_ovf   (rx_ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_data = '0; pop = 1'b0; push = 1'b0;
    D_push = '0; rd_en = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic tx_write(input logic [15:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic tx_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic rx_push(input logic [15:0] d);
    push = 1'b1; D_push = d;
    tick();
    push = 1'b0;
  endtask

  task automatic rx_read();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pndng"},    32'(pndng),    32'd0);
    check({tag, "_tx_full"},  32'(tx_full),  32'd0);
    check({tag, "_tx_count"}, 32'(tx_count), 32'd0);
    check({tag, "_rx_count"}, 32'(rx_count), 32'd0);
    check({tag, "_rx_empty"}, 32'(rx_empty), 32'd1);
    check({tag, "_tx_ovf"},   32'(tx_ovf),   32'd0);
    check({tag, "_rx_ovf"},   32'(rx_ovf),   32'd0);
    check({tag, "_D_pop"},    32'(D_pop),    32'd0);
    check({tag, "_rd_data"},  32'(rd_data),  32'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_reset_outputs("init");

    // Asynchronous reset mid-cycle with 3 TX entries and 1 RX entry.
    tx_write(16'h1111);
    tx_write(16'h2222);
    tx_write(16'h3333);
    rx_push(16'h4444);
    check("pre_rst_tx_count", 32'(tx_count), 32'd3);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_pndng", 32'(pndng), 32'd0);

    // Pop while empty is ignored.
    tx_pop();
    check("pop_empty_count", 32'(tx_count), 32'd0);

    // TX first-word fall-through.
    tx_write(16'h0A11);
    check("fwft_first_pndng", 32'(pndng), 32'd1);
    check("fwft_first_dpop",  32'(D_pop), 32'h0A11);
    tx_write(16'h0B22);
    check("fwft_head_hold",   32'(D_pop), 32'h0A11);
    tx_pop();
    check("fwft_pop1_dpop",   32'(D_pop), 32'h0B22);
    tx_pop();
    check("fwft_pop2_pndng",  32'(pndng), 32'd0);
    check("fwft_pop2_dpop",   32'(D_pop), 32'd0);

    // TX overflow: nine writes into a depth-8 queue.
    for (int i = 0; i < 9; i++) tx_write(16'h0100 + 16'(i));
    check("ovf_tx_full",  32'(tx_full),  32'd1);
    check("ovf_tx_ovf",   32'(tx_ovf),   32'd1);
    check("ovf_tx_count", 32'(tx_count), 32'd8);
    // Drop together with clear: flag stays set.
    wr_en = 1'b1; wr_data = 16'h0109; ovf_clr = 1'b1;
    tick();
    idle_inputs();
    check("ovf_clr_vs_drop", 32'(tx_ovf),   32'd1);
    check("ovf_clr_count",   32'(tx_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_order_%0d", i), 32'(D_pop), 32'h0100 + i);
      tx_pop();
    end
    check("ovf_drained_pndng", 32'(pndng), 32'd0);
    check("ovf_still_set",     32'(tx_ovf), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(tx_ovf), 32'd0);

    // Full TX: write and pop together.
    for (int i = 0; i < 8; i++) tx_write(16'h0200 + 16'(i));
    wr_en = 1'b1; wr_data = 16'h0300; pop = 1'b1;
    tick();
    idle_inputs();
    check("full_wrpop_count", 32'(tx_count), 32'd8);
    check("full_wrpop_ovf",   32'(tx_ovf),   32'd0);
    check("full_wrpop_full",  32'(tx_full),  32'd1);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("full_wrpop_order_%0d", i), 32'(D_pop), 32'h0200 + i);
      tx_pop();
    end
    check("full_wrpop_last", 32'(D_pop), 32'h0300);
    tx_pop();
    check("full_wrpop_empty", 32'(pndng), 32'd0);

    // Empty TX: write and pop together.
    wr_en = 1'b1; wr_data = 16'h0400; pop = 1'b1;
    tick();
    idle_inputs();
    check("empty_wrpop_count", 32'(tx_count), 32'd1);
    check("empty_wrpop_dpop",  32'(D_pop),    32'h0400);
    tx_pop();
    check("empty_wrpop_drain", 32'(tx_count), 32'd0);

    // RX path.
    for (int i = 0; i < 4; i++) rx_push(16'hFF00 + 16'(i));
    check("rx_count4", 32'(rx_count), 32'd4);
    check("rx_nonempty", 32'(rx_empty), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rx_order_%0d", i), 32'(rd_data), 32'hFF00 + i);
      rx_read();
    end
    check("rx_empty_after", 32'(rx_empty), 32'd1);
    check("rx_data_zero",   32'(rd_data),  32'd0);
    rx_read();
    check("rx_read_empty_count", 32'(rx_count), 32'd0);

    // RX overflow and independence from TX flag.
    for (int i = 0; i < 9; i++) rx_push(16'hE000 + 16'(i));
    check("rx_ovf",       32'(rx_ovf),   32'd1);
    check("rx_ovf_count", 32'(rx_count), 32'd8);
    check("rx_ovf_tx",    32'(tx_ovf),   32'd0);
    check("rx_ovf_head",  32'(rd_data),  32'hE000);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("rx_ovf_cleared", 32'(rx_ovf), 32'd0);
    for (int i = 0; i < 8; i++) rx_read();
    check("rx_ovf_drained", 32'(rx_empty), 32'd1);

    // Wrap-around: pointers cross depth-1 -> 0 several times.
    for (int i = 0; i < 20; i++) begin
      tx_write(16'h5000 + 16'(i));
      check($sformatf("wrap_data_%0d", i),  32'(D_pop),    32'h5000 + i);
      check($sformatf("wrap_cnt1_%0d", i),  32'(tx_count), 32'd1);
      tx_pop();
      check($sformatf("wrap_cnt0_%0d", i),  32'(tx_count), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule

// File: doc/bus_port_fifo.md
# bus_port_fifo

Per-driver port buffer between one host-side agent and the bus generator/arbiter. It holds packets waiting to go onto the bus and packets delivered by the bus. One instance sits on each of the `drvrs` ports. The transmit side drives the arbiter's `pndng`/`D_pop` and consumes its `pop`. The receive side captures the arbiter's `push`/`D_push` and presents them to the host.

## Interface

Parameters:
- `pckg_sz`, 16, packet width in bits; the upper 8 bits are the destination ID, not interpreted here.
- `depth`, 8, entries per queue; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  host writes `wr_data` into the TX queue.
- `wr_data`  in  `pckg_sz`  packet to transmit.
- `tx_full`  out  1  TX queue holds `depth` entries.
- `tx_count`  out  `$clog2(depth+1)`  TX occupancy.
- `pndng`  out  1  to arbiter: TX queue non-empty.
- `D_pop`  out  `pckg_sz`  to arbiter: TX head packet.
- `pop`  in  1  from arbiter: head consumed this cycle.
- `push`  in  1  from arbiter: `D_push` valid this cycle.
- `D_push`  in  `pckg_sz`  delivered packet.
- `rd_en`  in  1  host consumes the RX head.
- `rd_data`  out  `pckg_sz`  RX head packet.
- `rx_empty`  out  1  RX queue empty.
- `rx_count`  out  `$clog2(depth+1)`  RX occupancy.
- `tx_ovf`, `rx_ovf`  out  1  sticky drop flags.
- `ovf_clr`  in  1  clears both sticky flags.

## Operation

- Two independent circular queues, TX and RX. Each has a read pointer, a write pointer and a count. Pointers are `$clog2(depth)` bits and wrap naturally from `depth-1` to 0.
- **Output presentation (both queues):** first-word fall-through. `D_pop` and `rd_data` show the head entry combinationally from registered storage. Each forces to 0 while its queue is empty.
- **TX queue:**
  - `pndng = (tx_count != 0)`.
  - `pop` while empty is ignored.
  - `wr_en` while full and no pop: write dropped, `tx_ovf` set.
  - `wr_en` and `pop` together while full: both take effect; count unchanged.
  - `wr_en` and `pop` together while empty: write accepted, pop ignored; count becomes 1.
- **RX queue:** same rules, with `push` in place of `wr_en`, `rd_en` in place of `pop`, and `rx_ovf` as the drop flag.
- **Sticky flags:** `ovf_clr` clears both flags. A drop in the same cycle as `ovf_clr` wins, so the flag stays 1.
- **Not checked or modified:** packet contents, including the ID field.
- **Reset (asynchronous, any cycle):**
  - Outputs: `pndng=0`, `tx_full=0`, `tx_count=0`, `rx_count=0`, `rx_empty=1`, `tx_ovf=0`, `rx_ovf=0`, `D_pop=0`, `rd_data=0`.
  - Pointers return to 0. Storage is not cleared.
  - Packets in flight are discarded. Reset mid-operation needs no special handling.

## Timing

- Write-to-visible latency: a `wr_en` sampled at edge N raises `pndng` and presents `D_pop` after edge N. Same rule for `push` to `rx_empty`/`rd_data`.
- `pop` at edge N advances the head. The next entry appears on `D_pop` after edge N, or `pndng` falls if it was the last entry.
- `tx_full`, counts and flags are registered or derived from registered counts; they update the cycle after the causing edge.
- No combinational path from `pop` to `pndng`, or from `rd_en` to `rx_empty`. The arbiter samples `pndng` at the same edge it asserts `pop`, and must not pop twice for one entry.

## Structure

- **Package `bus_port_pkg`:**
  - function `cnt_w(depth)` returning `$clog2(depth+1)`.
  - constant `ID_MSB_OFS = 8` (ID field width, shared with the agent and checker).
- **Sub-module `sync_fifo`**, parameterised on `pckg_sz` and `depth`. It contains storage, pointers, count, full/empty, FWFT head with zero-when-empty, and the sticky overflow flag. Instantiated twice: TX and RX.
- **Top level:** wiring plus `pndng = ~tx_empty`.

## Test plan

- **Reset:** assert `reset` mid-cycle with 3 TX entries → all outputs at reset values immediately, without waiting for a clock; after release, `pndng=0`.
- **TX FWFT:** write `16'h0A11`, `16'h0B22` → `pndng=1`, `D_pop=16'h0A11`. Pop → `D_pop=16'h0B22`. Pop → `pndng=0`, `D_pop=0`.
- **TX overflow:** with `depth=8`, write 9 packets `16'h0100..16'h0108` → `tx_full=1`, `tx_ovf=1`, `tx_count=8`. Pops return `0100..0107` in order. `ovf_clr` → `tx_ovf=0`.
- **Simultaneous ops:**
  - Full TX, `wr_en`+`pop` together → count stays 8, no `tx_ovf`.
  - Empty TX, `wr_en`+`pop` together → count 1.
- **RX path:** 4 `push` of `16'hFF00..16'hFF03`, then 4 `rd_en` → `rd_data` in order, `rx_empty=1` after the last read.
- **Wrap-around:** 20 interleaved write/pop pairs on TX → data order preserved across pointer wrap; `tx_count` never exceeds 1.
